axi_read_arbiter: RTL and testbench



---
 rtl/axi_read_arbiter.sv | 161 ++++++++++++++++
 tb/tb_axi_read_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi_read_arbiter.sv
// Round-robin sharing of one AXI read master (AR/R) among NUM_REQ requesters.
// AR IDs are tagged with the winning index; R beats are steered back by that tag.
module axi_read_arbiter #(
   parameter int NUM_REQ    = 2,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 8,
   parameter int MAX_TXNS   = 8,
   parameter int IDX_W      = $clog2(NUM_REQ),
   parameter int MID_WIDTH  = ID_WIDTH + IDX_W
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic [NUM_REQ*ID_WIDTH-1:0]     s_arid,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]   s_araddr,
   input  logic [NUM_REQ*8-1:0]            s_arlen,
   input  logic [NUM_REQ*3-1:0]            s_arsize,
   input  logic [NUM_REQ*2-1:0]            s_arburst,
   input  logic [NUM_REQ*3-1:0]            s_arprot,
   input  logic [NUM_REQ-1:0]              s_arvalid,
   output logic [NUM_REQ-1:0]              s_arready,
   output logic [ID_WIDTH-1:0]             s_rid,
   output logic [DATA_WIDTH-1:0]           s_rdata,
   output logic [1:0]                      s_rresp,
   output logic                            s_rlast,
   output logic [NUM_REQ-1:0]              s_rvalid,
   input  logic [NUM_REQ-1:0]              s_rready,
   output logic [MID_WIDTH-1:0]            m_axi_arid,
   output logic [ADDR_WIDTH-1:0]           m_axi_araddr,
   output logic [7:0]                      m_axi_arlen,
   output logic [2:0]                      m_axi_arsize,
   output logic [1:0]                      m_axi_arburst,
   output logic [2:0]                      m_axi_arprot,
   output logic                            m_axi_arvalid,
   input  logic                            m_axi_arready,
   input  logic [MID_WIDTH-1:0]            m_axi_rid,
   input  logic [DATA_WIDTH-1:0]           m_axi_rdata,
   input  logic [1:0]                      m_axi_rresp,
   input  logic                            m_axi_rlast,
   input  logic                            m_axi_rvalid,
   output logic                            m_axi_rready,
   output logic                            busy_o
);

   localparam int CNT_W = $clog2(MAX_TXNS + 1);

   typedef enum logic {IDLE, HOLD} state_t;

   state_t           r_state;
   logic [IDX_W-1:0] r_grant;
   logic [IDX_W-1:0] r_rr_ptr;
   logic [CNT_W-1:0] r_outstanding;
   logic             r_arvalid;
   logic [MID_WIDTH-1:0]  r_arid;
   logic [ADDR_WIDTH-1:0] r_araddr;
   logic [7:0]       r_arlen;
   logic [2:0]       r_arsize;
   logic [1:0]       r_arburst;
   logic [2:0]       r_arprot;

   logic [IDX_W-1:0] w_cand;
   logic [IDX_W-1:0] w_grant;
   logic             w_found;
   logic             w_can_grant;
   logic             w_ar_hs;
   logic             w_r_done;
   logic [IDX_W-1:0] w_ridx;

   // Search starts one past the last winner; power-of-two NUM_REQ makes the wrap free.
   always_comb begin
      w_found = 1'b0;
      w_grant = '0;
      w_cand  = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         w_cand = r_rr_ptr + IDX_W'(i);
         if (!w_found && s_arvalid[w_cand]) begin
            w_found = 1'b1;
            w_grant = w_cand;
         end
      end
   end

   assign w_can_grant = !rst_i && (r_state == IDLE) && w_found &&
                        (r_outstanding < CNT_W'(MAX_TXNS));
   assign w_ar_hs     = r_arvalid && m_axi_arready;
   assign w_r_done    = m_axi_rvalid && m_axi_rready && m_axi_rlast;

   always_comb begin
      s_arready = '0;
      if (w_can_grant) s_arready[w_grant] = 1'b1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state   <= IDLE;
         r_grant   <= '0;
         r_rr_ptr  <= IDX_W'(NUM_REQ - 1);
         r_arvalid <= 1'b0;
         r_arid    <= '0;
         r_araddr  <= '0;
         r_arlen   <= '0;
         r_arsize  <= '0;
         r_arburst <= '0;
         r_arprot  <= '0;
      end else begin
         case (r_state)
            IDLE: if (w_can_grant) begin
               r_state   <= HOLD;
               r_arvalid <= 1'b1;
               r_grant   <= w_grant;
               r_arid    <= {w_grant, s_arid[int'(w_grant)*ID_WIDTH +: ID_WIDTH]};
               r_araddr  <= s_araddr[int'(w_grant)*ADDR_WIDTH +: ADDR_WIDTH];
               r_arlen   <= s_arlen[int'(w_grant)*8 +: 8];
               r_arsize  <= s_arsize[int'(w_grant)*3 +: 3];
               r_arburst <= s_arburst[int'(w_grant)*2 +: 2];
               r_arprot  <= s_arprot[int'(w_grant)*3 +: 3];
            end
            HOLD: if (m_axi_arready) begin
               r_state   <= IDLE;
               r_arvalid <= 1'b0;
               r_rr_ptr  <= r_grant;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Simultaneous issue and completion cancel; a stray completion at zero is ignored.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_outstanding <= '0;
      end else if (w_ar_hs && !w_r_done) begin
         r_outstanding <= r_outstanding + 1'b1;
      end else if (w_r_done && !w_ar_hs && (r_outstanding != '0)) begin
         r_outstanding <= r_outstanding - 1'b1;
      end
   end

   assign w_ridx = m_axi_rid[MID_WIDTH-1 -: IDX_W];

   always_comb begin
      s_rvalid         = '0;
      s_rvalid[w_ridx] = m_axi_rvalid;
   end

   assign m_axi_rready  = s_rready[w_ridx];
   assign s_rid         = m_axi_rid[ID_WIDTH-1:0];
   assign s_rdata       = m_axi_rdata;
   assign s_rresp       = m_axi_rresp;
   assign s_rlast       = m_axi_rlast;

   assign m_axi_arvalid = r_arvalid;
   assign m_axi_arid    = r_arid;
   assign m_axi_araddr  = r_araddr;
   assign m_axi_arlen   = r_arlen;
   assign m_axi_arsize  = r_arsize;
   assign m_axi_arburst = r_arburst;
   assign m_axi_arprot  = r_arprot;
   assign busy_o        = (r_state == HOLD) || (r_outstanding != '0);

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter: R-routing vector table plus AR/counter/reset sequences.
module tb_axi_read_arbiter;

   localparam int NREQ = 2;
   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int IW   = 8;
   localparam int MAXT = 4;
   localparam int MIDW = IW + 1;

   logic            clk_i = 1'b0;
   logic            rst_i;
   logic [NREQ*IW-1:0] s_arid;
   logic [NREQ*AW-1:0] s_araddr;
   logic [NREQ*8-1:0]  s_arlen;
   logic [NREQ*3-1:0]  s_arsize;
   logic [NREQ*2-1:0]  s_arburst;
   logic [NREQ*3-1:0]  s_arprot;
   logic [NREQ-1:0]    s_arvalid;
   logic [NREQ-1:0]    s_arready;
   logic [IW-1:0]      s_rid;
   logic [DW-1:0]      s_rdata;
   logic [1:0]         s_rresp;
   logic               s_rlast;
   logic [NREQ-1:0]    s_rvalid;
   logic [NREQ-1:0]    s_rready;
   logic [MIDW-1:0]    m_axi_arid;
   logic [AW-1:0]      m_axi_araddr;
   logic [7:0]         m_axi_arlen;
   logic [2:0]         m_axi_arsize;
   logic [1:0]         m_axi_arburst;
   logic [2:0]         m_axi_arprot;
   logic               m_axi_arvalid;
   logic               m_axi_arready;
   logic [MIDW-1:0]    m_axi_rid;
   logic [DW-1:0]      m_axi_rdata;
   logic [1:0]         m_axi_rresp;
   logic               m_axi_rlast;
   logic               m_axi_rvalid;
   logic               m_axi_rready;
   logic               busy_o;

   int n_checks = 0;
   int n_errors = 0;
   int pulses;

   axi_read_arbiter #(
      .NUM_REQ(NREQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MAX_TXNS(MAXT)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
      .s_arburst(s_arburst), .s_arprot(s_arprot), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
      .s_rvalid(s_rvalid), .s_rready(s_rready),
      .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
      .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arprot(m_axi_arprot),
      .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
      .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
      .busy_o(busy_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [MIDW-1:0] rid;
      logic            rvalid;
      logic [1:0]      rready;
      logic [DW-1:0]   rdata;
      logic [1:0]      exp_rvalid;
      logic [IW-1:0]   exp_rid;
      logic            exp_mready;
      logic [DW-1:0]   exp_rdata;
   } rvec_t;

   rvec_t vecs [6];

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      vecs[0] = '{9'h15A, 1'b1, 2'b01, 32'hDEAD_0001, 2'b10, 8'h5A, 1'b0, 32'hDEAD_0001};
      vecs[1] = '{9'h15A, 1'b1, 2'b10, 32'hDEAD_0002, 2'b10, 8'h5A, 1'b1, 32'hDEAD_0002};
      vecs[2] = '{9'h033, 1'b1, 2'b01, 32'h1234_5678, 2'b01, 8'h33, 1'b1, 32'h1234_5678};
      vecs[3] = '{9'h033, 1'b1, 2'b10, 32'h0BAD_F00D, 2'b01, 8'h33, 1'b0, 32'h0BAD_F00D};
      vecs[4] = '{9'h1FF, 1'b0, 2'b11, 32'h0000_0000, 2'b00, 8'hFF, 1'b1, 32'h0000_0000};
      vecs[5] = '{9'h000, 1'b0, 2'b00, 32'hFFFF_FFFF, 2'b00, 8'h00, 1'b0, 32'hFFFF_FFFF};

      rst_i = 1'b1;
      s_arid = {8'h22, 8'h11};
      s_araddr = {32'h0000_00B0, 32'h0000_00A0};
      s_arlen = '0; s_arsize = '0; s_arburst = '0; s_arprot = '0;
      s_arvalid = 2'b11;
      s_rready = 2'b00;
      m_axi_arready = 1'b1;
      m_axi_rid = '0; m_axi_rdata = '0; m_axi_rresp = '0;
      m_axi_rlast = 1'b0; m_axi_rvalid = 1'b0;
      #2;
      check("rst_arvalid", 64'(m_axi_arvalid), 64'd0);
      check("rst_arready", 64'(s_arready), 64'd0);
      check("rst_busy", 64'(busy_o), 64'd0);
      check("rst_araddr", 64'(m_axi_araddr), 64'd0);
      check("rst_count", 64'(dut.r_outstanding), 64'd0);
      tick(); tick();
      rst_i = 1'b0;

      // Alternating grants with arready tied high
      for (int k = 0; k < 4; k++) begin
         #1;
         check("t1_grant", 64'(s_arready), 64'(k % 2 == 0 ? 2'b01 : 2'b10));
         tick();
         check("t1_arvalid", 64'(m_axi_arvalid), 64'd1);
         check("t1_arid", 64'(m_axi_arid), (k % 2 == 0) ? 64'h011 : 64'h122);
         check("t1_araddr", 64'(m_axi_araddr), (k % 2 == 0) ? 64'hA0 : 64'hB0);
         check("t1_noready_hold", 64'(s_arready), 64'd0);
         tick();
      end
      check("t1_count", 64'(dut.r_outstanding), 64'd4);

      // Saturation at MAX_TXNS blocks further grants
      #1;
      check("t3_sat_ready", 64'(s_arready), 64'd0);
      check("t3_sat_busy", 64'(busy_o), 64'd1);
      tick();
      check("t3_sat_ready2", 64'(s_arready), 64'd0);
      m_axi_rid = {1'b1, 8'h22}; m_axi_rvalid = 1'b1; m_axi_rlast = 1'b1; s_rready = 2'b10;
      #1;
      check("t3_rready", 64'(m_axi_rready), 64'd1);
      check("t3_still_blocked", 64'(s_arready), 64'd0);
      tick();
      m_axi_rvalid = 1'b0;
      #1;
      check("t3_count_dec", 64'(dut.r_outstanding), 64'd3);
      check("t3_grant_after", 64'(s_arready), 64'b01);
      tick();

      // AR handshake and R completion in the same cycle
      m_axi_rid = {1'b0, 8'h11}; m_axi_rvalid = 1'b1; m_axi_rlast = 1'b1; s_rready = 2'b01;
      #1;
      check("t5_arvalid", 64'(m_axi_arvalid), 64'd1);
      tick();
      m_axi_rvalid = 1'b0; s_arvalid = 2'b00;
      #1;
      check("t5_count_same", 64'(dut.r_outstanding), 64'd3);
      check("t5_busy", 64'(busy_o), 64'd1);

      // Stalled AR: payload held, single arready pulse
      s_arvalid = 2'b10;
      s_araddr = {32'h0000_1000, 32'h0000_00A0};
      m_axi_arready = 1'b0;
      pulses = 0;
      #1;
      check("t2_grant1", 64'(s_arready), 64'b10);
      pulses += int'(s_arready[1]);
      tick();
      s_arvalid = 2'b00;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("t2_hold_valid", 64'(m_axi_arvalid), 64'd1);
         check("t2_hold_addr", 64'(m_axi_araddr), 64'h1000);
         pulses += int'(s_arready[1]);
         tick();
      end
      check("t2_pulses", 64'(pulses), 64'd1);
      m_axi_arready = 1'b1;
      tick();
      check("t2_count", 64'(dut.r_outstanding), 64'd4);

      // Drain, then a stray rlast at zero must not wrap
      m_axi_rid = {1'b0, 8'h11}; m_axi_rvalid = 1'b1; m_axi_rlast = 1'b1; s_rready = 2'b01;
      for (int i = 0; i < 4; i++) tick();
      check("drain_count", 64'(dut.r_outstanding), 64'd0);
      check("drain_busy", 64'(busy_o), 64'd0);
      tick();
      check("floor_count", 64'(dut.r_outstanding), 64'd0);
      m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;

      // R routing vector table
      for (int v = 0; v < 6; v++) begin
         m_axi_rid = vecs[v].rid; m_axi_rvalid = vecs[v].rvalid;
         s_rready = vecs[v].rready; m_axi_rdata = vecs[v].rdata;
         #2;
         check($sformatf("r%0d_svalid", v), 64'(s_rvalid), 64'(vecs[v].exp_rvalid));
         check($sformatf("r%0d_rid", v), 64'(s_rid), 64'(vecs[v].exp_rid));
         check($sformatf("r%0d_mready", v), 64'(m_axi_rready), 64'(vecs[v].exp_mready));
         check($sformatf("r%0d_rdata", v), 64'(s_rdata), 64'(vecs[v].exp_rdata));
      end
      m_axi_rvalid = 1'b0; s_rready = 2'b00;
      tick();
      check("r_count_untouched", 64'(dut.r_outstanding), 64'd0);

      // Reset during HOLD
      s_arvalid = 2'b01; m_axi_arready = 1'b1;
      #1;
      check("t6_grant0", 64'(s_arready), 64'b01);
      tick(); tick();
      s_arvalid = 2'b11; m_axi_arready = 1'b0;
      #1;
      check("t6_grant1", 64'(s_arready), 64'b10);
      tick();
      check("t6_hold_valid", 64'(m_axi_arvalid), 64'd1);
      check("t6_hold_busy", 64'(busy_o), 64'd1);
      #2;
      rst_i = 1'b1;
      #1;
      check("t6_async_valid", 64'(m_axi_arvalid), 64'd0);
      check("t6_async_busy", 64'(busy_o), 64'd0);
      check("t6_async_count", 64'(dut.r_outstanding), 64'd0);
      check("t6_rst_ready", 64'(s_arready), 64'd0);
      tick(); tick();
      rst_i = 1'b0;
      #1;
      check("t6_first_win", 64'(s_arready), 64'b01);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
